spi_slave_burst: RTL and testbench



---
 rtl/spi_slave_burst.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst.sv
// spi_slave_burst: SPI slave register-access port with burst read/write and
// address auto-increment. SCLK, CSB and MOSI are oversampled in the clk
// domain through 2-flop synchronisers. All four SPI modes are selected
// through CPOL/CPHA.
//
// Frame (MSB first): 8-bit command (bit7 = 1 read, 0 write), NB_ADDR-bit
// start address, then any number of NB_DATA-bit data words until CSB rises.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   sclk, csb, mosi    asynchronous SPI inputs
//   rd_data            read data, valid RD_LATENCY clks after rd_req
//   miso, miso_oe      master-in data and its output enable
//   addr_out           memory address, valid while wr_req/rd_req is high
//   wr_data            write data, valid while wr_req is high
//   wr_req, rd_req     single-cycle request strobes
//   busy               frame in progress
//   frame_err          single-cycle pulse when a frame ends mid-word
module spi_slave_burst #(
  parameter int NB_DATA    = 8,
  parameter int NB_ADDR    = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               csb,
  input  logic               mosi,
  input  logic [NB_DATA-1:0] rd_data,
  output logic               miso,
  output logic               miso_oe,
  output logic [NB_ADDR-1:0] addr_out,
  output logic [NB_DATA-1:0] wr_data,
  output logic               wr_req,
  output logic               rd_req,
  output logic               busy,
  output logic               frame_err
);

  localparam int MAXW_AD = (NB_ADDR > 8) ? NB_ADDR : 8;
  localparam int MAXW    = (NB_DATA > MAXW_AD) ? NB_DATA : MAXW_AD;
  localparam int CNT_W   = $clog2(MAXW);

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on falling.
  localparam logic SAMPLE_RISE = (CPOL == CPHA);
  localparam logic SCLK_IDLE   = (CPOL != 0);

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA
  } state_t;

  state_t state, state_nxt;

  logic [1:0] sclk_sync, csb_sync, mosi_sync;
  logic       sclk_prev, csb_prev;
  logic       sclk_s, csb_s, mosi_s;
  logic       sclk_edge, sample, csb_fall;

  logic [CNT_W-1:0] bit_cnt;
  logic [MAXW-2:0]  shift;
  logic [MAXW-1:0]  shift_nxt;
  logic             is_read;
  logic [NB_ADDR-1:0] addr;
  logic [NB_DATA-1:0] tx_word;
  logic [2:0]         lat_cnt;
  logic               latch_now;
  logic               active, field_last;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection.
  // The CSB chain resets low so that a CSB already low at reset release
  // never looks like a falling edge; a CSB already high just walks the
  // FSM from WAIT_CS to IDLE without a spurious edge either.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {2{SCLK_IDLE}};
      sclk_prev <= SCLK_IDLE;
      csb_sync  <= '0;
      csb_prev  <= 1'b0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sclk_prev <= sclk_sync[1];
      csb_sync  <= {csb_sync[0], csb};
      csb_prev  <= csb_sync[1];
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign csb_s     = csb_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);
  assign sample    = sclk_edge & ~csb_s;
  assign csb_fall  = ~csb_s & csb_prev;
  assign shift_nxt = {shift, mosi_s};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_CS;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    active     = 1'b0;
    field_last = 1'b0;

    case (state)
      CMD:   field_last = (bit_cnt == CNT_W'(7));
      ADDR:  field_last = (bit_cnt == CNT_W'(NB_ADDR - 1));
      WDATA: field_last = (bit_cnt == CNT_W'(NB_DATA - 1));
      RDATA: field_last = (bit_cnt == CNT_W'(NB_DATA - 1));
      default: field_last = 1'b0;
    endcase

    case (state)
      WAIT_CS: begin
        if (csb_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (csb_fall) state_nxt = CMD;
      end
      CMD: begin
        active = 1'b1;
        if (csb_s) state_nxt = IDLE;
        else if (sample && field_last) state_nxt = ADDR;
      end
      ADDR: begin
        active = 1'b1;
        if (csb_s) state_nxt = IDLE;
        else if (sample && field_last) state_nxt = is_read ? RDATA : WDATA;
      end
      WDATA, RDATA: begin
        active = 1'b1;
        if (csb_s) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_CS;
    endcase
  end

  assign busy    = active;
  assign miso_oe = (state == RDATA) && !csb_s;

  // MSB-first bit select of the transmit word by the current bit index.
  always_comb begin
    miso = 1'b0;
    if (state == RDATA) begin
      for (int unsigned i = 0; i < NB_DATA; i++) begin
        if (bit_cnt == CNT_W'(NB_DATA - 1 - i)) miso = tx_word[i];
      end
    end
  end

  // Reads are spaced a full word apart, far longer than RD_LATENCY, so a
  // single down-counter is enough to time the return of the one
  // outstanding read.
  assign latch_now = (RD_LATENCY == 0) ? rd_req : (lat_cnt == 3'd1);

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      is_read   <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      wr_req    <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;
      tx_word   <= '0;
      lat_cnt   <= '0;
    end else begin
      wr_req    <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;

      if (rd_req) lat_cnt <= 3'(RD_LATENCY);
      else if (lat_cnt != '0) lat_cnt <= lat_cnt - 3'd1;

      if (latch_now) tx_word <= rd_data;

      // Each request consumes the current address.
      if (wr_req || rd_req) addr <= addr + NB_ADDR'(1);

      if (active && csb_s) begin
        // End of frame: clean on a word boundary, error otherwise.
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
      end else if (!active) begin
        bit_cnt <= '0;
      end else if (sample) begin
        shift <= shift_nxt[MAXW-2:0];
        if (field_last) bit_cnt <= '0;
        else            bit_cnt <= bit_cnt + CNT_W'(1);

        if (state == CMD && bit_cnt == '0) is_read <= mosi_s;

        if (field_last) begin
          case (state)
            ADDR: begin
              addr   <= shift_nxt[NB_ADDR-1:0];
              rd_req <= is_read;
            end
            WDATA: begin
              wr_req  <= 1'b1;
              wr_data <= shift_nxt[NB_DATA-1:0];
            end
            RDATA: rd_req <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign addr_out = addr;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: five instances share sclk/mosi/reset, each has
// its own csb. Instance 0 is mode 0 with RD_LATENCY=1; instances 1..4 are
// modes 0..3 with RD_LATENCY=3. A small memory model answers reads.
module tb_spi_slave_burst;

  localparam int H = 100;  // SCLK half period in ns (10 clk periods)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [4:0] csb_v = '1;

  logic [4:0] miso_v, oe_v, wr_req_v, rd_req_v, busy_v, ferr_v;
  logic [7:0] addr_v  [5];
  logic [7:0] wdata_v [5];
  logic [7:0] rdata_v [5];

  logic [7:0] mem  [256];
  logic [7:0] pipe [5][3];

  int n_checks = 0;
  int n_pass   = 0;

  int         ev_n = 0;
  logic [7:0] ev_inst [64];
  logic       ev_wr   [64];
  logic [7:0] ev_addr [64];
  logic [7:0] ev_data [64];
  int         ferr_cnt [5] = '{default: 0};
  int         overlap_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int MODE = (g == 0) ? 0 : g - 1;
    spi_slave_burst #(
      .NB_DATA   (8),
      .NB_ADDR   (8),
      .CPOL      (MODE / 2),
      .CPHA      (MODE % 2),
      .RD_LATENCY((g == 0) ? 1 : 3)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .csb      (csb_v[g]),
      .mosi     (mosi),
      .rd_data  (rdata_v[g]),
      .miso     (miso_v[g]),
      .miso_oe  (oe_v[g]),
      .addr_out (addr_v[g]),
      .wr_data  (wdata_v[g]),
      .wr_req   (wr_req_v[g]),
      .rd_req   (rd_req_v[g]),
      .busy     (busy_v[g]),
      .frame_err(ferr_v[g])
    );
  end

  // Memory model: data for the address seen N cycles ago.
  always @(posedge clk) begin
    for (int g = 0; g < 5; g++) begin
      pipe[g][0] <= mem[addr_v[g]];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  always_comb begin
    for (int g = 0; g < 5; g++) rdata_v[g] = (g == 0) ? pipe[g][0] : pipe[g][2];
  end

  // Request / error monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 5; g++) begin
      if (wr_req_v[g] && rd_req_v[g]) overlap_cnt <= overlap_cnt + 1;
      if (ferr_v[g]) ferr_cnt[g] <= ferr_cnt[g] + 1;
      if ((wr_req_v[g] || rd_req_v[g]) && ev_n < 64) begin
        ev_inst[ev_n] <= 8'(g);
        ev_wr[ev_n]   <= wr_req_v[g];
        ev_addr[ev_n] <= addr_v[g];
        ev_data[ev_n] <= wr_req_v[g] ? wdata_v[g] : 8'h00;
        ev_n          <= ev_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_ev(input string tag, input int idx, input int inst,
                          input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic [31:0] got;
    got = '0;
    if (idx < 64) got = {7'd0, ev_wr[idx], ev_inst[idx], ev_addr[idx], ev_data[idx]};
    check(tag, got, {7'd0, wr, 8'(inst), a, d});
  endtask

  function automatic logic mode_cpol(input int inst);
    int m;
    m = (inst == 0) ? 0 : inst - 1;
    return (m / 2) != 0;
  endfunction

  function automatic logic mode_cpha(input int inst);
    int m;
    m = (inst == 0) ? 0 : inst - 1;
    return (m % 2) != 0;
  endfunction

  task automatic frame_start(input int inst);
    sclk = mode_cpol(inst);
    #H;
    csb_v[inst] = 1'b0;
    #H;
  endtask

  task automatic frame_end(input int inst);
    #H;
    csb_v[inst] = 1'b1;
    #(2 * H);
  endtask

  // Master shifts out nbits of tx (MSB first) and collects MISO.
  task automatic spi_word(input int inst, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic cpol, cpha;
    cpol = mode_cpol(inst);
    cpha = mode_cpha(inst);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        mosi = tx[7-k];
        #H;
        rx = {rx[6:0], miso_v[inst]};
        sclk = ~cpol;
        #H;
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = tx[7-k];
        #H;
        rx = {rx[6:0], miso_v[inst]};
        sclk = cpol;
        #H;
      end
    end
  endtask

  initial begin
    logic [7:0] rx, rx0, rx1;
    int base, f0;

    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'h01;
    mem[8'h21] = 8'h02;

    // Reset state
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ctrl", {26'd0, miso_v[0], oe_v[0], wr_req_v[0], rd_req_v[0], busy_v[0], ferr_v[0]}, 0);
    check("rst_addr", addr_v[0], 8'h00);
    check("rst_wdata", wdata_v[0], 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy_v, 5'b00000);

    // Single write, mode 0
    base = ev_n; f0 = ferr_cnt[0];
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    check("wr_oe_cmd", oe_v[0], 1'b0);
    spi_word(0, 8'h3C, 8, rx);
    check("wr_busy", busy_v[0], 1'b1);
    spi_word(0, 8'hA5, 8, rx);
    check("wr_oe_data", oe_v[0], 1'b0);
    frame_end(0);
    check("wr_n", ev_n - base, 1);
    check_ev("wr_ev", base, 0, 1'b1, 8'h3C, 8'hA5);
    check("wr_ferr", ferr_cnt[0] - f0, 0);
    check("wr_busy_end", busy_v[0], 1'b0);

    // Single read, mode 0, RD_LATENCY 1
    base = ev_n;
    frame_start(0);
    spi_word(0, 8'h80, 8, rx);
    check("rd_oe_cmd", oe_v[0], 1'b0);
    spi_word(0, 8'h10, 8, rx);
    spi_word(0, 8'h00, 8, rx);
    check("rd_oe_data", oe_v[0], 1'b1);
    frame_end(0);
    check("rd_oe_end", oe_v[0], 1'b0);
    check("rd_data", rx, 8'h5A);
    check("rd_n", ev_n - base, 2);
    check_ev("rd_ev0", base, 0, 1'b0, 8'h10, 8'h00);
    check_ev("rd_ev1", base + 1, 0, 1'b0, 8'h11, 8'h00);

    // Burst write with address wrap
    base = ev_n; f0 = ferr_cnt[0];
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'hFE, 8, rx);
    spi_word(0, 8'h11, 8, rx);
    spi_word(0, 8'h22, 8, rx);
    spi_word(0, 8'h33, 8, rx);
    frame_end(0);
    check("bw_n", ev_n - base, 3);
    check_ev("bw_ev0", base, 0, 1'b1, 8'hFE, 8'h11);
    check_ev("bw_ev1", base + 1, 0, 1'b1, 8'hFF, 8'h22);
    check_ev("bw_ev2", base + 2, 0, 1'b1, 8'h00, 8'h33);
    check("bw_ferr", ferr_cnt[0] - f0, 0);

    // Burst read in all four modes, RD_LATENCY 3
    for (int m = 1; m <= 4; m++) begin
      base = ev_n;
      frame_start(m);
      spi_word(m, 8'h80, 8, rx);
      spi_word(m, 8'h20, 8, rx);
      spi_word(m, 8'h00, 8, rx0);
      spi_word(m, 8'h00, 8, rx1);
      frame_end(m);
      check($sformatf("br%0d_rx0", m - 1), rx0, 8'h01);
      check($sformatf("br%0d_rx1", m - 1), rx1, 8'h02);
      check($sformatf("br%0d_n", m - 1), ev_n - base, 3);
      check_ev($sformatf("br%0d_ev0", m - 1), base, m, 1'b0, 8'h20, 8'h00);
      check_ev($sformatf("br%0d_ev1", m - 1), base + 1, m, 1'b0, 8'h21, 8'h00);
      check_ev($sformatf("br%0d_ev2", m - 1), base + 2, m, 1'b0, 8'h22, 8'h00);
      check($sformatf("br%0d_ferr", m - 1), ferr_cnt[m], 0);
    end

    // Abort after 5 data bits, then a clean frame
    base = ev_n; f0 = ferr_cnt[0];
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'h40, 8, rx);
    spi_word(0, 8'hB0, 5, rx);
    frame_end(0);
    check("ab_n", ev_n - base, 0);
    check("ab_ferr", ferr_cnt[0] - f0, 1);
    base = ev_n;
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'h41, 8, rx);
    spi_word(0, 8'h7E, 8, rx);
    frame_end(0);
    check("ab_next_n", ev_n - base, 1);
    check_ev("ab_next_ev", base, 0, 1'b1, 8'h41, 8'h7E);
    check("ab_next_ferr", ferr_cnt[0] - f0, 1);

    // Reset mid-address with csb held low
    f0 = ferr_cnt[0];
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'hC3, 4, rx);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_ctrl", {26'd0, miso_v[0], oe_v[0], wr_req_v[0], rd_req_v[0], busy_v[0], ferr_v[0]}, 0);
    check("mr_addr", addr_v[0], 8'h00);
    check("mr_wdata", wdata_v[0], 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    base = ev_n;
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'h12, 8, rx);
    spi_word(0, 8'h34, 8, rx);
    check("mr_busy", busy_v[0], 1'b0);
    check("mr_n", ev_n - base, 0);
    frame_end(0);
    check("mr_ferr", ferr_cnt[0] - f0, 0);
    base = ev_n;
    frame_start(0);
    spi_word(0, 8'h00, 8, rx);
    spi_word(0, 8'h05, 8, rx);
    spi_word(0, 8'h99, 8, rx);
    frame_end(0);
    check("mr_next_n", ev_n - base, 1);
    check_ev("mr_next_ev", base, 0, 1'b1, 8'h05, 8'h99);

    check("no_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
